// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared codes, debounce states and keymap for the keypad scanner
package keypad_scanner_pkg;

    localparam logic [4:0] DEF_BLANK_CODE = 5'd21;

    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_E    = 5'd14;
    localparam logic [4:0] KEY_F    = 5'd15;
    // Frame result meaning "no single key": outside 0..15 so it never aliases a key
    localparam logic [4:0] KEY_NONE = 5'd16;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_PRESS   = 2'd1,
        DB_HELD    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    // Physical keypad layout, indexed by row and column
    function automatic logic [4:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        case ({r, c})
            4'h0:    code = 5'd1;
            4'h1:    code = 5'd2;
            4'h2:    code = 5'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 5'd4;
            4'h5:    code = 5'd5;
            4'h6:    code = 5'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 5'd7;
            4'h9:    code = 5'd8;
            4'hA:    code = 5'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = 5'd0;
            4'hD:    code = KEY_F;
            4'hE:    code = KEY_E;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-frame press/release debounce FSM producing one accept pulse per press
module key_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int         DEBOUNCE_SCANS = 4,
    parameter logic [4:0] BLANK_CODE     = DEF_BLANK_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  logic [4:0] frame_key,
    output logic       accepted,
    output logic [4:0] code
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    db_state_t     state;
    logic [4:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + ONE;

    // Frame-rate FSM; the counter never passes LAST because reaching it always changes state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DB_IDLE;
            cand     <= KEY_NONE;
            cnt      <= '0;
            accepted <= 1'b0;
            code     <= BLANK_CODE;
        end else begin
            accepted <= 1'b0;
            if (frame_end) begin
                case (state)
                    DB_IDLE: begin
                        if (frame_key != KEY_NONE) begin
                            cand <= frame_key;
                            cnt  <= ONE;
                            if (LAST == ONE) begin
                                state    <= DB_HELD;
                                accepted <= 1'b1;
                                code     <= frame_key;
                            end else begin
                                state <= DB_PRESS;
                            end
                        end
                    end
                    DB_PRESS: begin
                        if (frame_key == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == LAST) begin
                                state    <= DB_HELD;
                                accepted <= 1'b1;
                                code     <= cand;
                            end
                        end else begin
                            state <= DB_IDLE;
                        end
                    end
                    DB_HELD: begin
                        if (frame_key == KEY_NONE) begin
                            cnt   <= ONE;
                            state <= (LAST == ONE) ? DB_IDLE : DB_RELEASE;
                        end
                    end
                    default: begin
                        if (frame_key == KEY_NONE) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == LAST) begin
                                state <= DB_IDLE;
                            end
                        end else begin
                            state <= DB_HELD;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner, frame decoder and 4-digit entry buffer
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int         SCAN_DIV       = 100000,
    parameter int         DEBOUNCE_SCANS = 4,
    parameter logic [4:0] BLANK_CODE     = DEF_BLANK_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic       clear_entry,
    output logic [3:0] col,
    output logic [4:0] key_code,
    output logic       key_valid,
    output logic [4:0] digit1,
    output logic [4:0] digit2,
    output logic [4:0] digit3,
    output logic [4:0] digit4,
    output logic [2:0] entry_count,
    output logic       entry_full
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          sample;
    logic          frame_end;
    logic [2:0]    acc_hits;
    logic [4:0]    acc_code;
    logic [2:0]    col_hits;
    logic [2:0]    tot_hits;
    logic [4:0]    col_code;
    logic [4:0]    cur_code;
    logic [4:0]    frame_key;
    logic [4:0]    digs [4];

    // Two-flop synchronizer; idle rows read as released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    assign sample    = (dwell == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    // Dwell counter and column index; index wraps naturally after column 3
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Count low rows in the strobed column and merge with what earlier columns of this frame saw
    always_comb begin
        col_hits = 3'd0;
        col_code = KEY_NONE;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = keymap(2'(r), col_idx);
            end
        end
        tot_hits  = acc_hits + col_hits;
        cur_code  = (col_hits != 3'd0) ? col_code : acc_code;
        frame_key = (tot_hits == 3'd1) ? cur_code : KEY_NONE;
    end

    // Frame accumulator; hit count saturates at 2 since only "exactly one" matters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hits <= 3'd0;
            acc_code <= KEY_NONE;
        end else if (frame_end) begin
            acc_hits <= 3'd0;
            acc_code <= KEY_NONE;
        end else if (sample) begin
            acc_hits <= (tot_hits >= 3'd2) ? 3'd2 : tot_hits;
            acc_code <= cur_code;
        end
    end

    key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .BLANK_CODE    (BLANK_CODE)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .frame_end(frame_end),
        .frame_key(frame_key),
        .accepted (key_valid),
        .code     (key_code)
    );

    // Entry buffer; clear wins over a store in the same cycle, full buffer drops further digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) digs[i] <= BLANK_CODE;
            entry_count <= 3'd0;
        end else if (clear_entry) begin
            for (int i = 0; i < 4; i++) digs[i] <= BLANK_CODE;
            entry_count <= 3'd0;
        end else if (key_valid && (key_code <= 5'd9) && (entry_count < 3'd4)) begin
            digs[entry_count[1:0]] <= key_code;
            entry_count            <= entry_count + 3'd1;
        end
    end

    assign digit1     = digs[0];
    assign digit2     = digs[1];
    assign digit3     = digs[2];
    assign digit4     = digs[3];
    assign entry_full = (entry_count == 3'd4);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic       clear_entry;
    logic [3:0] col;
    logic [4:0] key_code;
    logic       key_valid;
    logic [4:0] digit1, digit2, digit3, digit4;
    logic [2:0] entry_count;
    logic       entry_full;

    logic [15:0] press;
    int          vectors    = 0;
    int          miscompares = 0;
    int          pulses     = 0;
    logic [4:0]  last_code  = 5'd31;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2),
        .BLANK_CODE    (5'd21)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .clear_entry(clear_entry),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .digit4     (digit4),
        .entry_count(entry_count),
        .entry_full (entry_full)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is strobed
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                pulses++;
                last_code = key_code;
            end
        end
    endtask

    task automatic do_reset();
        press       = '0;
        clear_entry = 1'b0;
        rst         = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
    endtask

    // Press one key for 3 frames, then release for 3 frames
    task automatic enter_key(input int idx);
        press      = '0;
        press[idx] = 1'b1;
        run_cycles(48);
        press = '0;
        run_cycles(48);
    endtask

    initial begin
        press       = '0;
        clear_entry = 1'b0;
        rst         = 1'b0;

        // 1. reset state and column stepping
        do_reset();
        chk("rst_col", 32'(col), 32'(4'b1110));
        chk("rst_key_code", 32'(key_code), 32'd21);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_digit1", 32'(digit1), 32'd21);
        chk("rst_digit4", 32'(digit4), 32'd21);
        chk("rst_count", 32'(entry_count), 32'd0);
        chk("rst_full", 32'(entry_full), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 4)  chk("col_step1", 32'(col), 32'(4'b1101));
            if (i == 8)  chk("col_step2", 32'(col), 32'(4'b1011));
            if (i == 12) chk("col_step3", 32'(col), 32'(4'b0111));
            if (i == 16) chk("col_wrap", 32'(col), 32'(4'b1110));
        end

        // 2. key 5 (r1/c1) for 3 frames, then held 10 more
        do_reset();
        press[5] = 1'b1;
        run_cycles(48);
        chk("k5_pulses", 32'(pulses), 32'd1);
        chk("k5_code", 32'(last_code), 32'd5);
        chk("k5_digit1", 32'(digit1), 32'd5);
        chk("k5_count", 32'(entry_count), 32'd1);
        pulses = 0;
        run_cycles(160);
        chk("k5_hold_pulses", 32'(pulses), 32'd0);
        chk("k5_hold_count", 32'(entry_count), 32'd1);

        // 3. bounce on key 7 (r2/c0)
        do_reset();
        press[8] = 1'b1; run_cycles(16);
        press = '0;      run_cycles(16);
        press[8] = 1'b1; run_cycles(16);
        press = '0;      run_cycles(48);
        chk("bounce_pulses", 32'(pulses), 32'd0);
        chk("bounce_count", 32'(entry_count), 32'd0);

        // 4. fill the buffer with 1,2,3,4 then 9 overflows
        do_reset();
        enter_key(0);
        enter_key(1);
        enter_key(2);
        enter_key(4);
        chk("fill_pulses", 32'(pulses), 32'd4);
        chk("fill_digit1", 32'(digit1), 32'd1);
        chk("fill_digit2", 32'(digit2), 32'd2);
        chk("fill_digit3", 32'(digit3), 32'd3);
        chk("fill_digit4", 32'(digit4), 32'd4);
        chk("fill_full", 32'(entry_full), 32'd1);
        pulses = 0;
        enter_key(10);
        chk("ovf_pulses", 32'(pulses), 32'd1);
        chk("ovf_code", 32'(last_code), 32'd9);
        chk("ovf_count", 32'(entry_count), 32'd4);
        chk("ovf_digit4", 32'(digit4), 32'd4);

        // 5. command key A (r0/c3), then chord 1+2
        do_reset();
        enter_key(3);
        chk("a_pulses", 32'(pulses), 32'd1);
        chk("a_code", 32'(last_code), 32'd10);
        chk("a_count", 32'(entry_count), 32'd0);
        pulses   = 0;
        press[0] = 1'b1;
        press[1] = 1'b1;
        run_cycles(64);
        press = '0;
        run_cycles(32);
        chk("chord_pulses", 32'(pulses), 32'd0);
        chk("chord_code", 32'(key_code), 32'd10);

        // 6. clear in the key_valid cycle of key 8, then reset while held
        do_reset();
        enter_key(0);
        chk("pre_clear_count", 32'(entry_count), 32'd1);
        press[9] = 1'b1;
        run_cycles(31);
        @(negedge clk);
        chk("clr_valid", 32'(key_valid), 32'd1);
        chk("clr_code", 32'(key_code), 32'd8);
        clear_entry = 1'b1;
        @(negedge clk);
        clear_entry = 1'b0;
        chk("clr_count", 32'(entry_count), 32'd0);
        chk("clr_digit1", 32'(digit1), 32'd21);
        chk("clr_digit2", 32'(digit2), 32'd21);
        run_cycles(20);
        rst = 1'b0;
        #1;
        chk("arst_col", 32'(col), 32'(4'b1110));
        chk("arst_code", 32'(key_code), 32'd21);
        chk("arst_valid", 32'(key_valid), 32'd0);
        chk("arst_digit1", 32'(digit1), 32'd21);
        chk("arst_count", 32'(entry_count), 32'd0);
        chk("arst_full", 32'(entry_full), 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        run_cycles(16);
        chk("post_rst_frame1", 32'(pulses), 32'd0);
        run_cycles(16);
        chk("post_rst_frame2", 32'(pulses), 32'd1);
        chk("post_rst_code", 32'(last_code), 32'd8);
        run_cycles(1);
        chk("post_rst_digit1", 32'(digit1), 32'd8);
        chk("post_rst_count", 32'(entry_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
